// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes: single-cycle logic/arith/shift ops
// and an iterative shift-add multiplier that retires one multiplier bit per cycle.
module seq_alu #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             equal,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             zero_q, zero_d;
    logic             equal_q, equal_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             lost_q, lost_d;
    logic             movf_q, movf_d;
    logic             meq_q, meq_d;

    logic [WIDTH-1:0]        alu_z_s;
    logic                    alu_ovf_s;
    logic [WIDTH-1:0]        sum_s;
    logic [WIDTH-1:0]        diff_s;
    logic signed [WIDTH-1:0] x_sgn_s;
    logic [SHW-1:0]          shamt_s;
    logic                    reserved_s;
    logic                    accept_s;
    logic                    start_mul_s;
    logic [WIDTH:0]          add_s;

    assign in_ready    = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept_s    = in_valid & in_ready;
    assign start_mul_s = accept_s & (op == 3'd7) & MUL_EN;
    assign reserved_s  = (op == 3'd7) & ~MUL_EN;
    assign sum_s       = x + y;
    assign diff_s      = x - y;
    assign x_sgn_s     = x;
    assign shamt_s     = y[SHW-1:0];
    assign add_s       = {1'b0, acc_q} + {1'b0, mcand_q};

    // Single-cycle result and overflow for the operand pair on the inputs.
    always_comb begin
        alu_z_s   = {WIDTH{1'b0}};
        alu_ovf_s = 1'b0;
        case (op)
            3'd0: alu_z_s = x & y;
            3'd1: begin
                alu_z_s   = sum_s;
                alu_ovf_s = (x[WIDTH-1] == y[WIDTH-1]) & (sum_s[WIDTH-1] != x[WIDTH-1]);
            end
            3'd2: begin
                alu_z_s   = diff_s;
                alu_ovf_s = (x[WIDTH-1] != y[WIDTH-1]) & (diff_s[WIDTH-1] != x[WIDTH-1]);
            end
            3'd3: alu_z_s = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            3'd4: alu_z_s = x >> shamt_s;
            3'd5: alu_z_s = x_sgn_s >>> shamt_s;
            3'd6: alu_z_s = x << shamt_s;
            default: begin
                alu_z_s   = {WIDTH{1'b0}};
                alu_ovf_s = 1'b0;
            end
        endcase
    end

    // Next-state: handshake FSM plus multiplier iteration.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        z_d      = z_q;
        zero_d   = zero_q;
        equal_d  = equal_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        lost_d   = lost_q;
        movf_d   = movf_q;
        meq_d    = meq_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_mul_s) begin
                    state_d  = S_BUSY;
                    valid_d  = 1'b0;
                    acc_d    = {WIDTH{1'b0}};
                    mcand_d  = x;
                    mplier_d = y;
                    cnt_d    = {SHW{1'b0}};
                    lost_d   = 1'b0;
                    movf_d   = 1'b0;
                    meq_d    = (x == y);
                end else if (accept_s) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    z_d     = alu_z_s;
                    zero_d  = ~reserved_s & (alu_z_s == {WIDTH{1'b0}});
                    equal_d = ~reserved_s & (x == y);
                    ovf_d   = alu_ovf_s;
                end else if ((state_q == S_DONE) & out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_BUSY: begin
                // A set bit lost off the top of mcand means any later partial
                // product it contributes already exceeds WIDTH bits.
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                lost_d   = lost_q | mcand_q[WIDTH-1];
                if (mplier_q[0]) begin
                    acc_d  = add_s[WIDTH-1:0];
                    movf_d = movf_q | add_s[WIDTH] | lost_q;
                end else begin
                    acc_d  = acc_q;
                    movf_d = movf_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    z_d     = acc_d;
                    zero_d  = (acc_d == {WIDTH{1'b0}});
                    equal_d = meq_q;
                    ovf_d   = movf_d;
                end else begin
                    state_d = S_BUSY;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            z_q      <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            equal_q  <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= {WIDTH{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {SHW{1'b0}};
            lost_q   <= 1'b0;
            movf_q   <= 1'b0;
            meq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            z_q      <= z_d;
            zero_q   <= zero_d;
            equal_q  <= equal_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            lost_q   <= lost_d;
            movf_q   <= movf_d;
            meq_q    <= meq_d;
        end
    end

    assign out_valid = valid_q;
    assign z         = z_q;
    assign zero      = zero_q;
    assign equal     = equal_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for WIDTH=32, plus handshake,
// reset-abort and MUL_EN=0 sequences.
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] x, y, z;
    logic [2:0]   op;
    logic         zero, equal, overflow;

    logic         in_valid2, in_ready2, out_valid2, out_ready2;
    logic [W-1:0] x2, y2, z2;
    logic [2:0]   op2;
    logic         zero2, equal2, overflow2;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .zero(zero), .equal(equal), .overflow(overflow)
    );

    seq_alu #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .x(x2), .y(y2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2),
        .z(z2), .zero(zero2), .equal(equal2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [2:0]   op;
        logic [W-1:0] ez;
        logic         ezero;
        logic         eeq;
        logic         eovf;
        int           lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, keep in_valid high with junk while waiting, check result.
    task automatic run_vec(input vec_t v, input string tag);
        int   cycles;
        logic busy_bad;
        busy_bad = 1'b0;
        x = v.x; y = v.y; op = v.op; in_valid = 1'b1;
        chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        x = 32'hDEAD_BEEF; y = 32'h1234_5678; op = 3'd0;
        cycles = 1;
        while (!out_valid && cycles < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(cycles), 64'(v.lat));
        chk({tag, "_z"}, {32'd0, z}, {32'd0, v.ez});
        chk({tag, "_zero"}, {63'd0, zero}, {63'd0, v.ezero});
        chk({tag, "_eq"}, {63'd0, equal}, {63'd0, v.eeq});
        chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, v.eovf});
        if (v.op == 3'd7) chk({tag, "_busy_rdy"}, {63'd0, busy_bad}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic stable_ok;
        vec_t v;

        vecs[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, 3'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1};
        vecs[1]  = '{32'h1234_5678, 32'h1234_5678, 3'd2, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{32'h8000_0000, 32'h0000_001F, 3'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{32'h8000_0000, 32'h0000_001F, 3'd4, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[5]  = '{32'h0000_0001, 32'h0000_0020, 3'd6, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{32'h0001_0000, 32'h0001_0001, 3'd7, 32'h0001_0000, 1'b0, 1'b0, 1'b1, 33};
        vecs[7]  = '{32'h0000_0003, 32'h0000_0005, 3'd7, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 33};
        vecs[8]  = '{32'h0000_00F0, 32'h0000_003C, 3'd0, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 3'd1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1};
        vecs[10] = '{32'h8000_0000, 32'h0000_0001, 3'd2, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1};
        vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 33};
        vecs[12] = '{32'h0000_0000, 32'h0000_0005, 3'd7, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 33};
        vecs[13] = '{32'h0000_0005, 32'h0000_0005, 3'd3, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1};
        vecs[14] = '{32'h0000_FFFF, 32'h0001_0001, 3'd7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33};
        vecs[15] = '{32'h8000_0000, 32'h0000_0002, 3'd7, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 33};
        vecs[16] = '{32'hFFFF_0000, 32'h0F0F_0F0F, 3'd0, 32'h0F0F_0000, 1'b0, 1'b0, 1'b0, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; op = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; x2 = '0; y2 = '0; op2 = '0;
        #2;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_z", {32'd0, z}, 64'd0);
        chk("rst_flags", {61'd0, zero, equal, overflow}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Result held while the consumer stalls with a pending request.
        out_ready = 1'b0;
        x = 32'd1; y = 32'd2; op = 3'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        x = 32'hFF; y = 32'h0F; op = 3'd0;
        chk("stall_z0", {32'd0, z}, 64'h3);
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (z !== 32'h3 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                zero !== 1'b0 || equal !== 1'b0 || overflow !== 1'b0) stable_ok = 1'b0;
        end
        chk("stall_stable", {63'd0, stable_ok}, 64'd1);
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_z", {32'd0, z}, 64'h0F);
        @(posedge clk); #1;
        chk("b2b_retire", {63'd0, out_valid}, 64'd0);

        // Reset during a multiply aborts it.
        x = 32'd3; y = 32'd5; op = 3'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_z", {32'd0, z}, 64'd0);
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_no_result", {63'd0, out_valid}, 64'd0);
        v = '{32'h0000_00F0, 32'h0000_003C, 3'd0, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1};
        run_vec(v, "post_rst_and");

        // Reserved op on the multiplier-less variant.
        x2 = 32'd3; y2 = 32'd5; op2 = 3'd7; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        chk("nomul_valid", {63'd0, out_valid2}, 64'd1);
        chk("nomul_z", {32'd0, z2}, 64'd0);
        chk("nomul_ovf", {63'd0, overflow2}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
